// File: rtl/keypad_pkg.sv
// Shared keypad definitions: responder FSM states, scanner keycodes for digits 1..9
// and the digit -> row/column index mapping used by the responder, decoder and scanner bench.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESS   = 2'd1,
        ST_RELEASE = 2'd2
    } kp_state_t;

    // Keycode layout is {row0,row1,row2,col0,col1,col2}; entry [d] belongs to digit d.
    localparam logic [9:1][5:0] KP_KEYCODES = {
        6'b001001, 6'b001010, 6'b001100,
        6'b010001, 6'b010010, 6'b010100,
        6'b100001, 6'b100010, 6'b100100
    };

    function automatic logic kp_key_legal(input logic [3:0] d);
        return (d >= 4'd1) && (d <= 4'd9);
    endfunction

    function automatic logic [1:0] kp_row_idx(input logic [3:0] d);
        logic [3:0] t;
        t = d - 4'd1;
        return 2'(t / 4'd3);
    endfunction

    function automatic logic [1:0] kp_col_idx(input logic [3:0] d);
        logic [3:0] t;
        t = d - 4'd1;
        return 2'(t % 4'd3);
    endfunction

    function automatic logic [5:0] kp_keycode(input logic [3:0] d);
        return kp_key_legal(d) ? KP_KEYCODES[d] : 6'b000000;
    endfunction

endpackage

// File: rtl/keypad_hold_timer.sv
// Loadable down-counter shared by the hold and release-gap phases.
// Latency: load/decrement visible the cycle after. Backpressure: none; stops at zero.
// Zero flag is combinational from the count register.
module keypad_hold_timer #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/keypad_matrix_responder.sv
// 3x3 keypad contact model: accepts "press digit d for N cycles", answers scanner rows on col.
// Latency: contact closes the cycle after acceptance; col is combinational from row. Backpressure:
// req_ready low while pressing/releasing. Macro KEYPAD_BOUNCE_EN adds contact chatter.
module keypad_matrix_responder
    import keypad_pkg::*;
#(
    parameter int HOLD_W     = 26,
    parameter int GAP_CYC    = 16,
    parameter int BOUNCE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        row,
    output logic [2:0]        col,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_key,
    input  logic [HOLD_W-1:0] req_hold,
    output logic              pressed,
    output logic              busy,
    output logic              done,
    output logic              err
);

    if (GAP_CYC < 1) begin : g_bad_gap
        $error("GAP_CYC must be at least 1");
    end
    if (BOUNCE_CYC < 0) begin : g_bad_bounce
        $error("BOUNCE_CYC must not be negative");
    end

    kp_state_t   r_state;
    logic [2:0]  r_row_oh;
    logic [2:0]  r_col_oh;
    logic        r_pressed;
    logic        r_done;
    logic        r_err;

    logic              w_accept;
    logic              w_start;
    logic              w_zero;
    logic              w_press_end;
    logic              w_press_nxt;
    logic              w_rel_nxt;
    logic [HOLD_W-1:0] w_hold_m1;
    logic [HOLD_W-1:0] w_load_val;

    assign w_accept    = req_valid && (r_state == ST_IDLE);
    assign w_start     = w_accept && kp_key_legal(req_key);
    assign w_press_end = (r_state == ST_PRESS) && w_zero;

    // A zero hold is a one-cycle press, so the counter starts at max(hold,1)-1.
    assign w_hold_m1  = (req_hold == '0) ? '0 : req_hold - 1'b1;
    assign w_load_val = w_start ? w_hold_m1 : HOLD_W'(GAP_CYC - 1);

    keypad_hold_timer #(
        .W (HOLD_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_start || w_press_end),
        .i_load_val (w_load_val),
        .i_dec      (r_state != ST_IDLE),
        .o_zero     (w_zero)
    );

`ifdef KEYPAD_BOUNCE_EN
    localparam int BCW = $clog2(BOUNCE_CYC + 2);
    localparam logic [BCW-1:0] BOUNCE_V = BCW'(BOUNCE_CYC);

    // Cycle index within the current phase, saturating once chatter is over.
    logic [BCW-1:0] r_bcnt;
    logic [BCW-1:0] w_bnext;

    assign w_bnext     = (r_bcnt == BOUNCE_V) ? r_bcnt : r_bcnt + 1'b1;
    assign w_press_nxt = (w_bnext == BOUNCE_V) || !w_bnext[0];
    assign w_rel_nxt   = (w_bnext != BOUNCE_V) && w_bnext[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt <= '0;
        end else if (w_start || w_press_end) begin
            r_bcnt <= '0;
        end else begin
            r_bcnt <= w_bnext;
        end
    end
`else
    assign w_press_nxt = 1'b1;
    assign w_rel_nxt   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_row_oh  <= 3'b000;
            r_col_oh  <= 3'b000;
            r_pressed <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_row_oh  <= 3'b001 << kp_row_idx(req_key);
                        r_col_oh  <= 3'b001 << kp_col_idx(req_key);
                        r_pressed <= 1'b1;
                        r_state   <= ST_PRESS;
                    end else if (w_accept) begin
                        r_err <= 1'b1;
                    end
                end
                ST_PRESS: begin
                    if (w_zero) begin
                        r_pressed <= 1'b0;
                        r_state   <= ST_RELEASE;
                    end else begin
                        r_pressed <= w_press_nxt;
                    end
                end
                ST_RELEASE: begin
                    if (w_zero) begin
                        r_pressed <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_pressed <= w_rel_nxt;
                    end
                end
                default: begin
                    r_pressed <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Zero-latency column answer so the scanner sees it in the row-drive cycle.
    assign col       = (r_pressed && ((row & r_row_oh) != 3'b000)) ? r_col_oh : 3'b000;
    assign pressed   = r_pressed;
    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_keypad_matrix_responder.sv
// Randomized and directed stimulus for keypad_matrix_responder against a timeline reference model.
module tb_keypad_matrix_responder;
    import keypad_pkg::*;

    localparam int HOLD_W = 26;
    localparam int GAP    = 16;
    localparam int BOUNCE = 4;

    typedef struct {
        logic [3:0]        key;
        logic [HOLD_W-1:0] hold;
    } req_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2:0]        row;
    logic [2:0]        col;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_key;
    logic [HOLD_W-1:0] req_hold;
    logic              pressed;
    logic              busy;
    logic              done;
    logic              err;

    keypad_matrix_responder #(
        .HOLD_W     (HOLD_W),
        .GAP_CYC    (GAP),
        .BOUNCE_CYC (BOUNCE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_key   (req_key),
        .req_hold  (req_hold),
        .pressed   (pressed),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int     n_vec = 0;
    int     n_bad = 0;
    req_t   q[$];
    int     row_mode = 0;
    longint cyc = 0;

    // Reference model: the last legal acceptance and the last illegal acceptance.
    bit     have_acc = 0;
    longint acc_cyc  = 0;
    longint acc_hold = 0;
    int     acc_key  = 0;
    bit     have_err = 0;
    longint err_cyc  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Contact state k cycles after acceptance of a press lasting h cycles.
    function automatic bit contact(input longint k, input longint h);
        if (k < 0 || k >= h + GAP) return 1'b0;
`ifdef KEYPAD_BOUNCE_EN
        if (k < h) return (k < BOUNCE) ? (k % 2 == 0) : 1'b1;
        return ((k - h) < BOUNCE) && ((k - h) % 2 == 1);
`else
        return k < h;
`endif
    endfunction

    task automatic step();
        longint     k;
        bit         live;
        bit         e_pressed;
        logic [2:0] e_col;
        int         r;
        int         c;
        @(posedge clk);
        #1;
        cyc++;
        row = (row_mode == 0) ? (3'b001 << (cyc % 3)) : 3'($urandom_range(7, 0));
        if (q.size() > 0) begin
            req_valid = 1'b1;
            req_key   = q[0].key;
            req_hold  = q[0].hold;
        end else begin
            req_valid = 1'b0;
            req_key   = 4'($urandom);
            req_hold  = HOLD_W'($urandom);
        end
        @(negedge clk);
        k         = cyc - acc_cyc - 1;
        live      = have_acc && k >= 0 && k < acc_hold + GAP;
        e_pressed = have_acc && contact(k, acc_hold);
        r         = (acc_key - 1) / 3;
        c         = (acc_key - 1) % 3;
        e_col     = (e_pressed && row[r]) ? (3'b001 << c) : 3'b000;
        chk("pressed", 32'(pressed), 32'(e_pressed));
        chk("col", 32'(col), 32'(e_col));
        chk("req_ready", 32'(req_ready), 32'(!live));
        chk("busy", 32'(busy), 32'(live));
        chk("done", 32'(done), 32'(have_acc && k == acc_hold + GAP));
        chk("err", 32'(err), 32'(have_err && cyc == err_cyc + 1));
        if (row_mode == 0 && e_col != 3'b000)
            chk("keycode", 32'({row[0], row[1], row[2], col[0], col[1], col[2]}),
                32'(kp_keycode(4'(acc_key))));
        if (req_valid && !live) begin
            if (req_key >= 1 && req_key <= 9) begin
                have_acc = 1;
                acc_cyc  = cyc;
                acc_hold = (req_hold == 0) ? 1 : longint'(req_hold);
                acc_key  = int'(req_key);
            end else begin
                have_err = 1;
                err_cyc  = cyc;
            end
            void'(q.pop_front());
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain(input int budget);
        int b;
        b = budget;
        while (q.size() > 0 && b > 0) begin
            step();
            b--;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    task automatic push(input int key, input longint hold);
        req_t t;
        t.key  = 4'(key);
        t.hold = HOLD_W'(hold);
        q.push_back(t);
    endtask

    initial begin
        rst_n     = 1'b0;
        row       = 3'b111;
        req_valid = 1'b0;
        req_key   = 4'd0;
        req_hold  = '0;
        #3;
        chk("rst_pressed", 32'(pressed), 32'd0);
        chk("rst_col", 32'(col), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        push(5, 10);            run(40);
        push(9, 3);             run(30);
        push(0, 5); push(12, 7); run(10);
        push(1, 0);             run(25);
        push(3, 5); push(7, 4); drain(100); run(40);
`ifdef KEYPAD_BOUNCE_EN
        push(2, 8);             run(40);
`endif

        // All-ones hold must stay closed; then reset cuts the contact mid-press.
        push(4, (longint'(1) << HOLD_W) - 1);
        run(200);
        @(posedge clk);
        #1 row = 3'b010;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pressed", 32'(pressed), 32'd0);
        chk("arst_col", 32'(col), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        have_acc = 0;
        have_err = 0;
        run(40);

        row_mode = 1;
        for (int i = 0; i < 40; i++) begin
            push(int'($urandom_range(15, 0)), longint'($urandom_range(12, 0)));
            drain(200);
            run(int'($urandom_range(5, 0)));
        end
        row_mode = 0;
        for (int i = 0; i < 10; i++) begin
            push(int'($urandom_range(9, 1)), longint'($urandom_range(6, 0)));
        end
        drain(600);
        run(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
